id_ex_reg: RTL and testbench

//  - ID->EX pipeline register: captures decode-stage operands, sign-extended immediate,

---
 rtl/id_ex_reg.sv | 104 ++++++++++
 tb/tb_id_ex_reg.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID->EX pipeline register with stall, flush and valid bit
// Optional flush/stall perf counters are built when ID_EX_PERF_EN is defined.
module id_ex_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            reg_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            mem_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic [2:0]      alu_ctrl_d,
  input  logic            alu_src_d,
  output logic            valid_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            reg_write_e,
  output logic [1:0]      result_src_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic [2:0]      alu_ctrl_e,
  output logic            alu_src_e
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // A bubble clears every field, so rd_e=0 and the write enables can never
  // cause a spurious forward or side effect downstream.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      valid_e      <= 1'b0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      imm_ext_e    <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      result_src_e <= '0;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_ctrl_e   <= '0;
      alu_src_e    <= 1'b0;
    end else if (!stall_e) begin
      valid_e      <= valid_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      imm_ext_e    <= imm_ext_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      reg_write_e  <= reg_write_d;
      result_src_e <= result_src_d;
      mem_write_e  <= mem_write_d;
      jump_e       <= jump_d;
      branch_e     <= branch_d;
      alu_ctrl_e   <= alu_ctrl_d;
      alu_src_e    <= alu_src_d;
    end
  end

`ifdef ID_EX_PERF_EN
  // Saturating counters; a stall cycle overridden by flush counts only as a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (flush_e) begin
      if (bubble_cnt != {CNT_W{1'b1}}) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (stall_e) begin
      if (stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - scoreboard bench for id_ex_reg against a rule-level model
module tb_id_ex_reg;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    stall = 1'b0;
  logic    flush = 1'b0;
  fields_t din = '0;
  fields_t dout;
  fields_t model = '0;
  int      checks = 0;
  int      errors = 0;

  fields_t exp_q[$];
  string   name_q[$];
`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;
  int bc_model = 0, sc_model = 0;
  int bc_q[$], sc_q[$];
`endif

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall), .flush_e(flush),
    .valid_d(din.valid), .rd1_d(din.rd1), .rd2_d(din.rd2), .pc_d(din.pc),
    .pc_plus4_d(din.pc4), .imm_ext_d(din.imm), .rs1_d(din.rs1), .rs2_d(din.rs2),
    .rd_d(din.rd), .reg_write_d(din.reg_write), .result_src_d(din.result_src),
    .mem_write_d(din.mem_write), .jump_d(din.jump), .branch_d(din.branch),
    .alu_ctrl_d(din.alu_ctrl), .alu_src_d(din.alu_src),
    .valid_e(dout.valid), .rd1_e(dout.rd1), .rd2_e(dout.rd2), .pc_e(dout.pc),
    .pc_plus4_e(dout.pc4), .imm_ext_e(dout.imm), .rs1_e(dout.rs1), .rs2_e(dout.rs2),
    .rd_e(dout.rd), .reg_write_e(dout.reg_write), .result_src_e(dout.result_src),
    .mem_write_e(dout.mem_write), .jump_e(dout.jump), .branch_e(dout.branch),
    .alu_ctrl_e(dout.alu_ctrl), .alu_src_e(dout.alu_src)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // One cycle of stimulus; the expected register contents after the edge are
  // decided from the priority rules: reset, then flush, then stall, else load.
  task automatic step(input logic r, input logic s, input logic f, input fields_t d, input string nm);
    @(negedge clk);
    rst_n = r; stall = s; flush = f; din = d;
    if (!r || f) model = '0;
    else if (!s) model = d;
    exp_q.push_back(model);
    name_q.push_back(nm);
`ifdef ID_EX_PERF_EN
    if (!r) begin bc_model = 0; sc_model = 0; end
    else if (f) bc_model = (bc_model < CMAX) ? bc_model + 1 : CMAX;
    else if (s) sc_model = (sc_model < CMAX) ? sc_model + 1 : CMAX;
    bc_q.push_back(bc_model);
    sc_q.push_back(sc_model);
`endif
  endtask

  function automatic fields_t rand_fields();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return fields_t'(r[185:0]);
  endfunction

  // Monitor: every edge with a pending expectation is compared after it settles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        fields_t e;
        string nm;
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (dout !== e) begin
          errors++;
          $display("FAIL %s: got %h want %h", nm, dout, e);
        end
`ifdef ID_EX_PERF_EN
        begin
          int eb, es;
          eb = bc_q.pop_front();
          es = sc_q.pop_front();
          checks++;
          if (int'(bubble_cnt) != eb || int'(stall_cnt) != es) begin
            errors++;
            $display("FAIL %s counters: got b=%0d s=%0d want b=%0d s=%0d",
                     nm, bubble_cnt, stall_cnt, eb, es);
          end
        end
`endif
      end
    end
  end

  initial begin
    fields_t d;
    fields_t ones;
    int waited;
    ones = '1;

    step(1'b0, 1'b0, 1'b0, ones, "reset0");
    step(1'b0, 1'b0, 1'b0, ones, "reset1");

    d = '0; d.pc = 32'h40; d.imm = 32'hFFFF_FFF8; d.rd = 5'd5; d.reg_write = 1'b1; d.valid = 1'b1;
    step(1'b1, 1'b0, 1'b0, d, "load");
    d.pc = 32'h44;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, d, "stall_hold");
    step(1'b1, 1'b0, 1'b0, d, "stall_release");

    d.mem_write = 1'b1;
    step(1'b1, 1'b1, 1'b1, d, "flush_over_stall");

    step(1'b1, 1'b0, 1'b0, rand_fields(), "preload");
    step(1'b1, 1'b1, 1'b0, rand_fields(), "pre_reset_stall");
    step(1'b0, 1'b1, 1'b0, rand_fields(), "reset_mid_stall");
    step(1'b1, 1'b0, 1'b0, rand_fields(), "post_reset_load");
    step(1'b0, 1'b0, 1'b1, rand_fields(), "reset_mid_flush");

    d = rand_fields(); d.valid = 1'b0;
    step(1'b1, 1'b0, 1'b0, d, "invalid_load");

    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), rand_fields(), "random");

    step(1'b0, 1'b0, 1'b0, rand_fields(), "perf_reset");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, rand_fields(), "perf_flush");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, rand_fields(), "perf_stall_flush");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, rand_fields(), "perf_stall");

    @(negedge clk);
    stall = 1'b1;
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
